// File: rtl/absdiff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : absdiff_pkg
// Purpose  : Shared types and constants for the absolute-difference scheduler.
//            - state_t  : controller states (2-bit encoding)
//            - req_id_t : requester identifier (0 or 1)
//            - DEF_WIDTH: default operand width
// Revision : 1.0 - initial release
// ============================================================================
package absdiff_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage : absdiff_pkg
`default_nettype wire

// File: rtl/absdiff_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : absdiff_sched_if
// Purpose  : Bundles the two request ports and the response port of the
//            absolute-difference scheduler.
//   reqN_valid/reqN_ready/reqN_x/reqN_y : request handshake + operands, N=0,1
//   rsp_valid/rsp_ready/rsp_data/rsp_id : response handshake, |x-y| and owner
//   modport master : requester / response-consumer side
//   modport slave  : scheduler side
// Revision : 1.0 - initial release
// ============================================================================
interface absdiff_sched_if #(
  parameter int WIDTH = absdiff_pkg::DEF_WIDTH
);

  logic                 req0_valid;
  logic                 req0_ready;
  logic [WIDTH-1:0]     req0_x;
  logic [WIDTH-1:0]     req0_y;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [WIDTH-1:0]     req1_x;
  logic [WIDTH-1:0]     req1_y;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH:0]       rsp_data;
  absdiff_pkg::req_id_t rsp_id;

  modport master (
    output req0_valid, req0_x, req0_y,
    input  req0_ready,
    output req1_valid, req1_x, req1_y,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_x, req0_y,
    output req0_ready,
    input  req1_valid, req1_x, req1_y,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready
  );

endinterface : absdiff_sched_if
`default_nettype wire

// File: rtl/absdiff_pipe.sv
`default_nettype none
// ============================================================================
// Module   : absdiff_pipe
// Purpose  : Pipelined unsigned |x-y|. The difference is formed in the first
//            register stage and then delayed through LAT-1 further stages.
//   clk, rst           : clock, synchronous active-high reset (clears valids)
//   in_valid/in_x/in_y : operands to inject
//   out_valid/out_data : result, in_valid delayed exactly LAT cycles
// Revision : 1.0 - initial release
// ============================================================================
module absdiff_pipe #(
  parameter int WIDTH = 5,
  parameter int LAT   = 2   // legal range 1..8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  output logic [WIDTH:0]   out_data
);

  logic [WIDTH:0]   w_diff;
  logic [LAT-1:0]   valid_d, valid_q;
  logic [WIDTH:0]   data_d [LAT];
  logic [WIDTH:0]   data_q [LAT];

  // Zero-extend before subtracting so the larger-minus-smaller form never
  // wraps; the MSB therefore always reads 0.
  always_comb begin
    w_diff = (in_x > in_y) ? ({1'b0, in_x} - {1'b0, in_y})
                           : ({1'b0, in_y} - {1'b0, in_x});
  end

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    valid_d[0] = in_valid;
    data_d[0]  = w_diff;
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_data  = data_q[LAT-1];

endmodule : absdiff_pipe
`default_nettype wire

// File: rtl/absdiff_sched.sv
`default_nettype none
// ============================================================================
// Module   : absdiff_sched
// Purpose  : Round-robin scheduler sharing one pipelined |x-y| datapath
//            between two requesters, one transaction in flight at a time.
//   clk  : system clock
//   rst  : synchronous active-high reset (aborts any transaction)
//   bus  : absdiff_sched_if.slave - two request ports + one response port
//   busy : high whenever the controller is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module absdiff_sched
  import absdiff_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = 2   // legal range 1..8
) (
  input  logic           clk,
  input  logic           rst,
  absdiff_sched_if.slave bus,
  output logic           busy
);

  state_t           state_d, state_q;
  req_id_t          last_grant_d, last_grant_q;
  req_id_t          id_d, id_q;
  logic [WIDTH-1:0] x_d, x_q;
  logic [WIDTH-1:0] y_d, y_q;
  logic             inject_d, inject_q;
  logic             rsp_valid_d, rsp_valid_q;
  logic [WIDTH:0]   rsp_data_d, rsp_data_q;
  req_id_t          rsp_id_d, rsp_id_q;
  logic             busy_d, busy_q;

  logic             w_grant0, w_grant1;
  logic             w_ready0, w_ready1;
  logic             w_pipe_valid;
  logic [WIDTH:0]   w_pipe_data;

  // On a tie, the requester that was not granted last time wins.
  assign w_grant0 = bus.req0_valid & (~bus.req1_valid |  last_grant_q);
  assign w_grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
  assign w_ready0 = (state_q == IDLE) & w_grant0;
  assign w_ready1 = (state_q == IDLE) & w_grant1;

  // Operands are injected from the capture registers one cycle after the
  // handshake, so the request ports are free to change immediately.
  absdiff_pipe #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inject_q),
    .in_x      (x_q),
    .in_y      (y_q),
    .out_valid (w_pipe_valid),
    .out_data  (w_pipe_data)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    x_d          = x_q;
    y_d          = y_q;
    inject_d     = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (w_ready0 | w_ready1) begin
          id_d         = w_ready1;
          last_grant_d = w_ready1;
          x_d          = w_ready1 ? bus.req1_x : bus.req0_x;
          y_d          = w_ready1 ? bus.req1_y : bus.req0_y;
          inject_d     = 1'b1;
          busy_d       = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (w_pipe_valid) begin
          rsp_data_d  = w_pipe_data;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      inject_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      x_q          <= x_d;
      y_q          <= y_d;
      inject_q     <= inject_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign busy           = busy_q;

endmodule : absdiff_sched
`default_nettype wire

// File: tb/tb_absdiff_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_absdiff_sched
// Purpose  : Self-checking bench for absdiff_sched. A transaction-level model
//            (owner flag, countdown to the response, last winner) predicts
//            ready, busy and the response port every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_absdiff_sched;

  localparam int W   = 5;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  absdiff_sched_if #(.WIDTH(W)) bus ();

  absdiff_sched #(
    .WIDTH (W),
    .LAT   (LAT)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_active;   // a transaction owns the datapath
  bit m_rsp;      // response is being presented
  int m_cnt;      // edges left until the response appears
  bit m_last;     // last requester granted
  bit m_id;
  int m_res;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // against the model, then advance the model to the next rising edge.
  task automatic step(input bit v0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                      input bit v1, input logic [W-1:0] x1, input logic [W-1:0] y1,
                      input bit rr, input bit r);
    bit g;
    bit e_r0, e_r1;
    int a, b;
    @(negedge clk);
    rst            = r;
    bus.req0_valid = v0; bus.req0_x = x0; bus.req0_y = y0;
    bus.req1_valid = v1; bus.req1_x = x1; bus.req1_y = y1;
    bus.rsp_ready  = rr;
    #1;
    if (v0 && !v1)      g = 1'b0;
    else if (v1 && !v0) g = 1'b1;
    else                g = !m_last;
    e_r0 = !m_active && v0 && (g == 1'b0);
    e_r1 = !m_active && v1 && (g == 1'b1);
    check_eq("req0_ready", bus.req0_ready, e_r0);
    check_eq("req1_ready", bus.req1_ready, e_r1);
    check_eq("ready_onehot", bus.req0_ready & bus.req1_ready, 0);
    check_eq("rsp_valid", bus.rsp_valid, m_rsp);
    check_eq("busy", busy, m_active);
    if (m_rsp) begin
      check_eq("rsp_data", bus.rsp_data, m_res);
      check_eq("rsp_id", bus.rsp_id, m_id);
    end
    if (r) begin
      m_active = 0; m_rsp = 0; m_last = 1;
    end else if (m_rsp) begin
      if (rr) begin
        m_rsp = 0; m_active = 0;
      end
    end else if (m_active) begin
      m_cnt--;
      if (m_cnt == 0) m_rsp = 1;
    end else if (v0 || v1) begin
      a        = g ? int'(x1) : int'(x0);
      b        = g ? int'(y1) : int'(y0);
      m_res    = (a > b) ? a - b : b - a;
      m_id     = g;
      m_last   = g;
      m_active = 1;
      m_cnt    = LAT + 1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_valid = 0; bus.req0_x = 0; bus.req0_y = 0;
    bus.req1_valid = 0; bus.req1_x = 0; bus.req1_y = 0;
    bus.rsp_ready  = 1;
    m_active = 0; m_rsp = 0; m_cnt = 0; m_last = 1; m_id = 0; m_res = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_rsp_valid", bus.rsp_valid, 0);
    check_eq("reset_rsp_data", bus.rsp_data, 0);
    check_eq("reset_rsp_id", bus.rsp_id, 0);
    check_eq("reset_busy", busy, 0);

    // Single request from requester 0; operand change one cycle after accept
    step(1, 5, 10, 0, 0, 0, 1, 0);
    step(1, 20, 10, 0, 0, 0, 1, 0);
    step(0, 20, 10, 0, 0, 0, 1, 0);
    idle_cycles(LAT + 3);

    // Tie-break and strict alternation under continuous requests
    for (int i = 0; i < 4 * (LAT + 3); i++) step(1, 5, 10, 1, 12, 3, 1, 0);
    idle_cycles(LAT + 3);

    // Boundary operands
    step(1, 31, 0, 0, 0, 0, 1, 0);  idle_cycles(LAT + 3);
    step(0, 0, 0, 1, 0, 31, 1, 0);  idle_cycles(LAT + 3);
    step(1, 17, 17, 0, 0, 0, 1, 0); idle_cycles(LAT + 3);

    // Back-pressure with requester 1 waiting throughout
    step(1, 9, 2, 1, 4, 30, 1, 0);
    for (int i = 0; i < LAT + 11; i++) step(0, 0, 0, 1, 4, 30, 0, 0);
    for (int i = 0; i < LAT + 4; i++)  step(0, 0, 0, 1, 4, 30, 1, 0);
    idle_cycles(LAT + 3);

    // Reset while BUSY, then a tie must go to requester 0
    step(0, 0, 0, 1, 7, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle_cycles(LAT + 2);
    step(1, 3, 8, 1, 8, 3, 1, 0);
    idle_cycles(LAT + 3);

    // Randomized traffic with random back-pressure and rare resets
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), W'($urandom_range(0, 31)), W'($urandom_range(0, 31)),
           bit'($urandom_range(0, 1)), W'($urandom_range(0, 31)), W'($urandom_range(0, 31)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_absdiff_sched
`default_nettype wire
